// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory responder with programmable wait states
// Optional MEM_ERR_EN: flags misaligned / out-of-range requests instead of wrapping.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_in_err;
    logic          w_write;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_wdata;
    logic          w_unused_addr;

`ifdef MEM_ERR_EN
    assign w_in_err = (i_req_addr[1:0] != 2'b00) || (|i_req_addr[31:AW+2]);
`else
    assign w_in_err = 1'b0;
`endif
    assign w_unused_addr = ^{i_req_addr[1:0], i_req_addr[31:AW+2]};

    assign w_accept = i_req_valid && (r_state == IDLE);
    assign w_access = (w_next == RESP);

    // With zero wait states the access happens on the accept edge, so take operands straight from the inputs.
    assign w_write = (r_state == IDLE) ? i_req_write : r_write;
    assign w_err   = (r_state == IDLE) ? w_in_err : r_err;
    assign w_idx   = (r_state == IDLE) ? i_req_addr[AW+1:2] : r_idx;
    assign w_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_STATES > 0) ? BUSY : RESP;
            BUSY:    if (r_cnt == 4'd1) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (r_state == IDLE);
        o_rsp_valid = (r_state == RESP);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_write <= i_req_write;
                r_idx   <= i_req_addr[AW+1:2];
                r_wdata <= i_req_wdata;
                r_err   <= w_in_err;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_rsp_err <= w_access && w_err;
            if (w_access) begin
                r_rsp_rdata <= w_err ? 32'd0 : (w_write ? w_wdata : r_mem[w_idx]);
            end
        end
    end

    // Gated by reset so a request held during reset cannot write the array.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_access && w_write && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule
